// File: rtl/trap_controller_pkg.sv
// Shared constants and types for the machine trap controller: CSR map,
// cause codes and FSM state encoding.
package trap_controller_pkg;

    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;

    localparam logic [31:0] CAUSE_INSTR_MISALIGNED = 32'd0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } trap_state_e;

    // Trap vector base: low two bits are mode/reserved and always read as zero.
    function automatic logic [31:0] tvec_base(input logic [31:0] value);
        return value & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/trap_controller_if.sv
// Signal bundle between the exception detector / CSR port and the trap
// controller, plus the front-end flush/redirect outputs.
interface trap_controller_if;
    import trap_controller_pkg::*;

    // exc_valid and mret_valid are level qualifiers sampled on every rising
    // edge; there is no ready/backpressure, a request arriving while the
    // controller is busy is simply dropped.
    logic        exc_valid;
    logic [31:0] exc_code;
    logic [31:0] exc_pc;
    logic [31:0] exc_tval;
    logic        mret_valid;
    logic        csr_wr_en;
    logic [11:0] csr_addr;
    logic [31:0] csr_wr_data;
    logic [31:0] csr_rd_data;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_busy;
    trap_state_e dbg_state;

    modport master (
        output exc_valid, exc_code, exc_pc, exc_tval, mret_valid,
               csr_wr_en, csr_addr, csr_wr_data,
        input  csr_rd_data, flush, redirect_valid, redirect_pc, trap_busy,
               dbg_state
    );

    modport slave (
        input  exc_valid, exc_code, exc_pc, exc_tval, mret_valid,
               csr_wr_en, csr_addr, csr_wr_data,
        output csr_rd_data, flush, redirect_valid, redirect_pc, trap_busy,
               dbg_state
    );

endinterface

// File: rtl/trap_controller_csr_file.sv
// Machine trap CSR storage (mtvec, mscratch, mepc, mcause, mtval) with
// software write port, hardware trap capture and combinational read mux.
module trap_csr_file
    import trap_controller_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [11:0] addr,
    input  logic [31:0] wr_data,
    input  logic        capture,
    input  logic [31:0] cap_epc,
    input  logic [31:0] cap_cause,
    input  logic [31:0] cap_tval,
    output logic [31:0] rd_data,
    output logic [31:0] mtvec,
    output logic [31:0] mepc
);

    logic [31:0] mscratch;
    logic [31:0] mcause;
    logic [31:0] mtval;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mtvec    <= RESET_MTVEC;
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
            mtval    <= '0;
        end else begin
            if (wr_en) begin
                case (addr)
                    CSR_MTVEC:    mtvec    <= tvec_base(wr_data);
                    CSR_MSCRATCH: mscratch <= wr_data;
                    CSR_MEPC:     mepc     <= wr_data;
                    CSR_MCAUSE:   mcause   <= wr_data;
                    CSR_MTVAL:    mtval    <= wr_data;
                    default:      ;
                endcase
            end
            // Placed after the software write so a same-edge trap capture wins.
            if (capture) begin
                mepc   <= cap_epc;
                mcause <= cap_cause;
                mtval  <= cap_tval;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            CSR_MTVEC:    rd_data = mtvec;
            CSR_MSCRATCH: rd_data = mscratch;
            CSR_MEPC:     rd_data = mepc;
            CSR_MCAUSE:   rd_data = mcause;
            CSR_MTVAL:    rd_data = mtval;
            default:      rd_data = '0;
        endcase
    end

endmodule

// File: rtl/trap_controller.sv
// Machine trap controller: captures exceptions, flushes the front end for
// FLUSH_CYCLES cycles, then redirects to mtvec; mret redirects to mepc.
module trap_controller
    import trap_controller_pkg::*;
#(
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] RESET_MTVEC  = 32'h0000_0004
) (
    input logic             clk,
    input logic             rst_n,
    trap_controller_if.slave bus
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    trap_state_e state, state_next;
    logic [3:0]  count, count_next;
    logic        mret_pulse, mret_next;
    logic        capture;
    logic [31:0] mtvec;
    logic [31:0] mepc;

    trap_csr_file #(
        .RESET_MTVEC (RESET_MTVEC)
    ) u_csr (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (bus.csr_wr_en),
        .addr      (bus.csr_addr),
        .wr_data   (bus.csr_wr_data),
        .capture   (capture),
        .cap_epc   (bus.exc_pc),
        .cap_cause (bus.exc_code & 32'h7FFF_FFFF),
        .cap_tval  (bus.exc_tval),
        .rd_data   (bus.csr_rd_data),
        .mtvec     (mtvec),
        .mepc      (mepc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            mret_pulse <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            mret_pulse <= mret_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        capture    = 1'b0;
        mret_next  = 1'b0;
        case (state)
            IDLE: begin
                // An exception takes priority over a coincident mret.
                if (bus.exc_valid) begin
                    capture    = 1'b1;
                    state_next = FLUSH;
                    count_next = FLUSH_LOAD;
                end else if (bus.mret_valid) begin
                    mret_next = 1'b1;
                end
            end
            FLUSH: begin
                if (count == 4'd0) begin
                    state_next = REDIRECT;
                end else begin
                    count_next = count - 4'd1;
                end
            end
            REDIRECT: state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Outputs decode only registered state, so they change on clock edges only.
    // mret_pulse is set solely from IDLE, so it never overlaps REDIRECT.
    always_comb begin
        bus.flush          = (state != IDLE) || mret_pulse;
        bus.redirect_valid = (state == REDIRECT) || mret_pulse;
        bus.trap_busy      = (state != IDLE);
        bus.dbg_state      = state;
        bus.redirect_pc    = '0;
        if (state == REDIRECT) begin
            bus.redirect_pc = tvec_base(mtvec);
        end else if (mret_pulse) begin
            bus.redirect_pc = mepc;
        end
    end

endmodule

// File: tb/tb_trap_controller.sv
// Directed plus randomized bench for trap_controller against a cycle-count
// reference model of the trap/mret/CSR rules.
module tb_trap_controller;
    import trap_controller_pkg::*;

    localparam int          FC    = 2;
    localparam logic [31:0] RTVEC = 32'h0000_0004;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    trap_controller_if bus ();

    trap_controller #(
        .FLUSH_CYCLES (FC),
        .RESET_MTVEC  (RTVEC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: trap progress is a count of busy cycles still to run
    // (0 = idle, 1 = the redirect cycle).
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    int          m_left;
    bit          m_mret;

    logic [11:0] addr_pool [6] = '{CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
                                   CSR_MCAUSE, CSR_MTVAL, 12'h7C0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            CSR_MTVEC:    return m_mtvec;
            CSR_MSCRATCH: return m_mscratch;
            CSR_MEPC:     return m_mepc;
            CSR_MCAUSE:   return m_mcause;
            CSR_MTVAL:    return m_mtval;
            default:      return 32'h0;
        endcase
    endfunction

    task automatic model_edge();
        bit busy;
        if (!rst_n) begin
            m_mtvec = RTVEC; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
            m_left = 0; m_mret = 0;
            return;
        end
        busy = (m_left > 0);
        if (bus.csr_wr_en) begin
            case (bus.csr_addr)
                CSR_MTVEC:    m_mtvec    = {bus.csr_wr_data[31:2], 2'b00};
                CSR_MSCRATCH: m_mscratch = bus.csr_wr_data;
                CSR_MEPC:     m_mepc     = bus.csr_wr_data;
                CSR_MCAUSE:   m_mcause   = bus.csr_wr_data;
                CSR_MTVAL:    m_mtval    = bus.csr_wr_data;
                default:      ;
            endcase
        end
        m_mret = !busy && !bus.exc_valid && bus.mret_valid;
        if (!busy && bus.exc_valid) begin
            m_mepc   = bus.exc_pc;
            m_mcause = {1'b0, bus.exc_code[30:0]};
            m_mtval  = bus.exc_tval;
            m_left   = FC + 1;
        end else if (busy) begin
            m_left = m_left - 1;
        end
    endtask

    task automatic step();
        logic [31:0] exp_pc;
        logic [1:0]  exp_state;
        model_edge();
        @(posedge clk);
        #1;
        exp_pc    = (m_left == 1) ? {m_mtvec[31:2], 2'b00} : (m_mret ? m_mepc : 32'h0);
        exp_state = (m_left == 0) ? 2'd0 : ((m_left == 1) ? 2'd2 : 2'd1);
        check("flush", 32'(bus.flush), 32'(m_left > 0 || m_mret));
        check("redirect_valid", 32'(bus.redirect_valid), 32'(m_left == 1 || m_mret));
        check("redirect_pc", bus.redirect_pc, exp_pc);
        check("trap_busy", 32'(bus.trap_busy), 32'(m_left > 0));
        check("dbg_state", 32'(bus.dbg_state), 32'(exp_state));
        check("csr_rd_data", bus.csr_rd_data, m_read(bus.csr_addr));
    endtask

    task automatic drive_idle();
        bus.exc_valid   = 1'b0;
        bus.mret_valid  = 1'b0;
        bus.csr_wr_en   = 1'b0;
    endtask

    task automatic drive_exc(input logic [31:0] code, input logic [31:0] pc, input logic [31:0] tval);
        bus.exc_valid = 1'b1;
        bus.exc_code  = code;
        bus.exc_pc    = pc;
        bus.exc_tval  = tval;
    endtask

    task automatic read_csr(input string tag, input logic [11:0] a, input logic [31:0] exp);
        bus.csr_addr = a;
        #1;
        check(tag, bus.csr_rd_data, exp);
    endtask

    initial begin
        int redirects;
        rst_n = 1'b0;
        drive_idle();
        drive_exc(32'h0, 32'h0, 32'h0);
        bus.exc_valid   = 1'b0;
        bus.csr_addr    = CSR_MTVEC;
        bus.csr_wr_data = 32'h0;

        // Reset and mtvec reset value
        step(); step();
        rst_n = 1'b1;
        read_csr("reset_mtvec", CSR_MTVEC, 32'h0000_0004);
        check("reset_flush", 32'(bus.flush), 32'h0);
        check("reset_redirect", 32'(bus.redirect_valid), 32'h0);

        // Misaligned trap: flush 3 cycles, redirect to 0x4 on the third
        drive_exc(CAUSE_INSTR_MISALIGNED, 32'h100, 32'h102);
        step();
        drive_idle();
        redirects = 0;
        for (int i = 0; i < 3; i++) begin
            check("trap_flush_window", 32'(bus.flush), 32'h1);
            if (i < 2) step();
        end
        check("trap_redirect_cycle", 32'(bus.redirect_valid), 32'h1);
        check("trap_redirect_pc", bus.redirect_pc, 32'h4);
        step();
        check("trap_done_flush", 32'(bus.flush), 32'h0);
        read_csr("trap_mepc", CSR_MEPC, 32'h100);
        read_csr("trap_mtval", CSR_MTVAL, 32'h102);
        read_csr("trap_mcause", CSR_MCAUSE, 32'h0);

        // mret redirects to mepc for one cycle
        bus.mret_valid = 1'b1;
        step();
        bus.mret_valid = 1'b0;
        check("mret_pc", bus.redirect_pc, 32'h100);
        step();
        check("mret_one_cycle", 32'(bus.redirect_valid), 32'h0);

        // Exception and mret together, then a nested exception during FLUSH
        drive_exc(32'h8000_0000, 32'h100, 32'h55);
        bus.mret_valid = 1'b1;
        step();
        bus.mret_valid = 1'b0;
        check("collision_no_mret", 32'(bus.redirect_valid), 32'h0);
        drive_exc(32'h1, 32'h200, 32'h66);
        step();
        drive_idle();
        for (int i = 0; i < 3; i++) step();
        read_csr("nested_mepc", CSR_MEPC, 32'h100);
        read_csr("collision_mcause", CSR_MCAUSE, 32'h0);

        // mtvec write during FLUSH retargets the pending redirect
        drive_exc(32'h0, 32'h300, 32'h302);
        step();
        drive_idle();
        bus.csr_wr_en   = 1'b1;
        bus.csr_addr    = CSR_MTVEC;
        bus.csr_wr_data = 32'h8000_0003;
        step();
        bus.csr_wr_en = 1'b0;
        step();
        check("mtvec_wr_redirect_pc", bus.redirect_pc, 32'h8000_0000);
        step();

        // Reset in the middle of FLUSH: trap abandoned, nothing redirects
        drive_exc(32'h0, 32'h400, 32'h402);
        step();
        drive_idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.redirect_valid) redirects++;
        end
        check("reset_abort_redirects", 32'(redirects), 32'h0);
        read_csr("reset_abort_mepc", CSR_MEPC, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            bus.exc_valid   = ($urandom_range(0, 7) == 0);
            bus.exc_code    = $urandom;
            bus.exc_pc      = $urandom;
            bus.exc_tval    = $urandom;
            bus.mret_valid  = ($urandom_range(0, 5) == 0);
            bus.csr_wr_en   = ($urandom_range(0, 4) == 0);
            bus.csr_addr    = addr_pool[$urandom_range(0, 5)];
            bus.csr_wr_data = $urandom;
            rst_n           = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
